fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble encoding (addi x0,x0,0) driven when no valid instruction is present.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge; one clock only.
REQ-004 rst_ni  input  1  reset; asynchronous, active-low.
REQ-005 instr_req_o  output  1  fetch request; the memory accepts it in the same cycle.
REQ-006 instr_addr_o  output  32  fetch address; meaningful only while instr_req_o=1.
REQ-007 instr_rvalid_i  input  1  response valid; arrives at least 1 cycle after its request.
REQ-008 instr_rdata_i  input  32  response instruction word.
REQ-009 stall_i  input  1  decode cannot accept; hold the IF/ID outputs.
REQ-010 branch_taken_i  input  1  redirect request from execute.
REQ-011 branch_target_i  input  32  redirect address.
REQ-012 instruction_o  output  32  IF/ID instruction, feeding the decode immediate generator.
REQ-013 pc_o  output  32  address of instruction_o.
REQ-014 valid_o  output  1  instruction_o/pc_o hold a real instruction.

Function
REQ-015 SHALL keep next_pc (the next address to fetch) and req_pc (the address of the outstanding request).
REQ-016 SHALL implement FSM states IDLE (nothing outstanding), WAIT (one request outstanding) and DROP (outstanding response to discard).
REQ-017 SHALL allow at most one outstanding request.
REQ-018 SHALL define "sink free" as (!valid_o || !stall_i) && !skid_valid.
REQ-019 IDLE: instr_req_o = !skid_valid && !branch_taken_i; on a request, instr_addr_o=next_pc, req_pc<=next_pc, next_pc<=next_pc+4 (modulo 2^32), go to WAIT.
REQ-020 WAIT, rvalid, no redirect: deliver {rdata, req_pc} to IF/ID if sink free, otherwise to the skid buffer.
REQ-021 In the REQ-020 case, if the response was delivered to IF/ID, SHALL issue the next request in the same cycle (stay in WAIT); otherwise go to IDLE.
REQ-022 WAIT, redirect: next_pc<=branch_target_i; go to IDLE if rvalid in the same cycle (the response is discarded), else go to DROP; no request is issued that cycle.
REQ-023 DROP: discard the response on rvalid and go to IDLE; a redirect in DROP updates next_pc and keeps the state DROP; no requests are issued in DROP.
REQ-024 The skid buffer SHALL be 1 entry {instr, pc, skid_valid}.
REQ-025 When IF/ID advances (!stall_i || !valid_o), the skid entry SHALL be loaded first, and then skid_valid<=0.
REQ-026 When IF/ID advances with no skid entry and no delivered response, SHALL load valid_o<=0 and instruction_o<=NOP_INSTR; pc_o holds its value.
REQ-027 While valid_o && stall_i, SHALL hold instruction_o, pc_o and valid_o unchanged.
REQ-028 branch_taken_i SHALL take priority over everything: valid_o<=0, instruction_o<=NOP_INSTR, skid_valid<=0, regardless of stall_i.
REQ-029 Latency: a request in cycle n with rvalid in cycle n+k SHALL produce valid_o=1 in cycle n+k+1 when unstalled.
REQ-030 Sustained throughput SHALL be 1 instruction/cycle when k=1 and there is no stall.

Reset
REQ-031 On rst_ni=0, SHALL set: state IDLE, next_pc=RESET_PC, req_pc=RESET_PC, skid_valid=0, valid_o=0, instruction_o=NOP_INSTR, pc_o=RESET_PC.
REQ-032 instr_req_o SHALL be 0 during reset; the first request is issued in the first cycle after deassertion.
REQ-033 A response arriving after reset for a request issued before reset SHALL be ignored, since the state is IDLE.

Structure
REQ-034 RESET_PC default, NOP_INSTR and the FSM state encoding SHALL live in the shared core package.
REQ-035 The skid buffer SHALL be the sub-module fetch_skid_buffer; everything else is flat.

Verification
REQ-036 Reset release, memory k=1 returning 0x00500093 at 0x0 and 0x00A00113 at 0x4 -> req at 0x0 then 0x4 on consecutive cycles; valid_o/pc_o = 0x0 then 0x4 on consecutive cycles.
REQ-037 stall_i=1 for 3 cycles while valid_o=1 with a response arriving -> outputs held; the skid fills; no request issued; after stall release the skid instruction appears next cycle with no loss or duplication.
REQ-038 branch_taken_i=1 with target 0x100 while in WAIT, rvalid 2 cycles later -> the stale response is dropped; the next request addresses 0x100; valid_o=0 until the 0x100 instruction returns.
REQ-039 Redirect coinciding with rvalid and stall_i=1 -> IF/ID flushed to NOP_INSTR, skid empty, next request addresses the target.
REQ-040 next_pc=0xFFFFFFFC -> the following request addresses 0x00000000.
REQ-041 rst_ni asserted mid-WAIT -> outputs at reset values immediately (asynchronous); the first post-reset request addresses RESET_PC; the late rvalid is ignored.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared core definitions for the instruction fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  // IDLE: nothing outstanding, WAIT: one request outstanding,
  // DROP: outstanding response must be discarded after a redirect.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry holding slot for a response that arrived while decode stalled.
module fetch_skid_buffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic [31:0] load_instr,
  input  logic [31:0] load_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // Drain (flush or hand-off to IF/ID) wins over a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (drain) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single outstanding request, redirect handling,
// and a one-entry skid buffer in front of the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  fetch_state_e state;
  logic [31:0]  next_pc;
  logic [31:0]  req_pc;

  logic         skid_valid;
  logic [31:0]  skid_instr;
  logic [31:0]  skid_pc;

  logic         advance;
  logic         sink_free;
  logic         deliver;
  logic         fetch_req;
  logic         skid_load;
  logic         skid_drain;

  // Handshake decode: when IF/ID may move, whether a response is accepted,
  // and whether a new request goes out this cycle.
  always_comb begin
    advance    = !stall_i || !valid_o;
    sink_free  = advance && !skid_valid;
    deliver    = (state == WAIT) && instr_rvalid_i && !branch_taken_i;
    // skid_valid implies no request is outstanding, so a delivery that cannot
    // reach IF/ID always finds the skid slot empty.
    skid_load  = deliver && !sink_free;
    skid_drain = branch_taken_i || (advance && skid_valid);
    fetch_req  = 1'b0;
    unique case (state)
      IDLE:    fetch_req = !skid_valid && !branch_taken_i;
      WAIT:    fetch_req = deliver && sink_free;
      default: fetch_req = 1'b0;
    endcase
    instr_req_o  = rst_ni && fetch_req;
    instr_addr_o = next_pc;
  end

  fetch_skid_buffer u_skid (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .load       (skid_load),
    .drain      (skid_drain),
    .load_instr (instr_rdata_i),
    .load_pc    (req_pc),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc         (skid_pc)
  );

  // Fetch FSM, PC tracking and the IF/ID output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      next_pc       <= RESET_PC;
      req_pc        <= RESET_PC;
      valid_o       <= 1'b0;
      instruction_o <= NOP_INSTR;
      pc_o          <= RESET_PC;
    end else begin
      if (branch_taken_i) begin
        next_pc <= branch_target_i;
      end else if (fetch_req) begin
        req_pc  <= next_pc;
        next_pc <= next_pc + 32'd4;
      end

      unique case (state)
        IDLE: if (fetch_req) state <= WAIT;
        WAIT: begin
          if (branch_taken_i)      state <= instr_rvalid_i ? IDLE : DROP;
          else if (instr_rvalid_i) state <= fetch_req ? WAIT : IDLE;
        end
        DROP: if (instr_rvalid_i) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (branch_taken_i) begin
        valid_o       <= 1'b0;
        instruction_o <= NOP_INSTR;
      end else if (advance) begin
        if (skid_valid) begin
          valid_o       <= 1'b1;
          instruction_o <= skid_instr;
          pc_o          <= skid_pc;
        end else if (deliver) begin
          valid_o       <= 1'b1;
          instruction_o <= instr_rdata_i;
          pc_o          <= req_pc;
        end else begin
          valid_o       <= 1'b0;
          instruction_o <= NOP_INSTR;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        valid_o;

  int total = 0;
  int bad   = 0;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .instr_req_o     (instr_req_o),
    .instr_addr_o    (instr_addr_o),
    .instr_rvalid_i  (instr_rvalid_i),
    .instr_rdata_i   (instr_rdata_i),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .instruction_o   (instruction_o),
    .pc_o            (pc_o),
    .valid_o         (valid_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      default:       return addr ^ 32'h5A5A_0013;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive(input logic rv, input logic [31:0] rd, input logic st,
                       input logic br, input logic [31:0] tg);
    instr_rvalid_i  = rv;
    instr_rdata_i   = rd;
    stall_i         = st;
    branch_taken_i  = br;
    branch_target_i = tg;
    #1;
  endtask

  task automatic exp_req(input string tag, input logic r, input logic [31:0] a);
    check_eq({tag, "_req"}, {31'd0, instr_req_o}, {31'd0, r});
    if (r) check_eq({tag, "_addr"}, instr_addr_o, a);
  endtask

  task automatic exp_ifid(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
    check_eq({tag, "_valid"}, {31'd0, valid_o}, {31'd0, v});
    check_eq({tag, "_pc"}, pc_o, pc);
    check_eq({tag, "_instr"}, instruction_o, instr);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    @(negedge clk_i);
    @(negedge clk_i);
    exp_ifid("rst", 1'b0, 32'h0, NOP);
    exp_req("rst", 1'b0, 32'h0);
    rst_ni = 1'b1;
    #1;
  endtask

  initial begin
    // Back-to-back fetch with 1-cycle memory
    do_reset();
    exp_req("s1c0", 1'b1, 32'h0);
    next_cycle();
    drive(1'b1, mem_word(32'h0), 1'b0, 1'b0, '0);
    exp_req("s1c1", 1'b1, 32'h4);
    next_cycle();
    exp_ifid("s1c2", 1'b1, 32'h0, 32'h0050_0093);
    drive(1'b1, mem_word(32'h4), 1'b0, 1'b0, '0);
    exp_req("s1c2", 1'b1, 32'h8);
    next_cycle();
    exp_ifid("s1c3", 1'b1, 32'h4, 32'h00A0_0113);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    next_cycle();
    exp_ifid("s1c4", 1'b0, 32'h4, NOP);

    // Stall for 3 cycles while a response lands in the skid buffer
    do_reset();
    next_cycle();
    drive(1'b1, mem_word(32'h0), 1'b0, 1'b0, '0);
    next_cycle();
    exp_ifid("s2c2", 1'b1, 32'h0, 32'h0050_0093);
    drive(1'b1, mem_word(32'h4), 1'b1, 1'b0, '0);
    exp_req("s2c2", 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      exp_ifid("s2hold", 1'b1, 32'h0, 32'h0050_0093);
      drive(1'b0, '0, 1'b1, 1'b0, '0);
      exp_req("s2hold", 1'b0, 32'h0);
    end
    next_cycle();
    exp_ifid("s2rel", 1'b1, 32'h0, 32'h0050_0093);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    exp_req("s2rel", 1'b0, 32'h0);
    next_cycle();
    exp_ifid("s2skid", 1'b1, 32'h4, 32'h00A0_0113);
    exp_req("s2skid", 1'b1, 32'h8);
    next_cycle();
    exp_ifid("s2gap", 1'b0, 32'h4, NOP);
    drive(1'b1, mem_word(32'h8), 1'b0, 1'b0, '0);
    exp_req("s2gap", 1'b1, 32'hC);
    next_cycle();
    exp_ifid("s2next", 1'b1, 32'h8, mem_word(32'h8));
    drive(1'b0, '0, 1'b0, 1'b0, '0);

    // Redirect in WAIT, stale response two cycles later
    do_reset();
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b1, 32'h100);
    exp_req("s3br", 1'b0, 32'h0);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    exp_req("s3drop0", 1'b0, 32'h0);
    next_cycle();
    exp_ifid("s3drop1", 1'b0, 32'h0, NOP);
    drive(1'b1, mem_word(32'h0), 1'b0, 1'b0, '0);
    exp_req("s3drop1", 1'b0, 32'h0);
    next_cycle();
    exp_ifid("s3stale", 1'b0, 32'h0, NOP);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    exp_req("s3tgt", 1'b1, 32'h100);
    next_cycle();
    exp_ifid("s3wait", 1'b0, 32'h0, NOP);
    drive(1'b1, mem_word(32'h100), 1'b0, 1'b0, '0);
    exp_req("s3wait", 1'b1, 32'h104);
    next_cycle();
    exp_ifid("s3got", 1'b1, 32'h100, mem_word(32'h100));
    drive(1'b0, '0, 1'b0, 1'b0, '0);

    // Redirect coinciding with rvalid while stalled
    do_reset();
    next_cycle();
    drive(1'b1, mem_word(32'h0), 1'b0, 1'b0, '0);
    next_cycle();
    exp_ifid("s4c2", 1'b1, 32'h0, 32'h0050_0093);
    drive(1'b1, mem_word(32'h4), 1'b1, 1'b1, 32'h200);
    exp_req("s4br", 1'b0, 32'h0);
    next_cycle();
    exp_ifid("s4flush", 1'b0, 32'h0, NOP);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    exp_req("s4tgt", 1'b1, 32'h200);
    next_cycle();
    exp_ifid("s4noskid", 1'b0, 32'h0, NOP);
    drive(1'b1, mem_word(32'h200), 1'b0, 1'b0, '0);
    next_cycle();
    exp_ifid("s4got", 1'b1, 32'h200, mem_word(32'h200));
    drive(1'b0, '0, 1'b0, 1'b0, '0);

    // next_pc wrap at the top of the address space
    do_reset();
    next_cycle();
    drive(1'b1, mem_word(32'h0), 1'b0, 1'b1, 32'hFFFF_FFFC);
    next_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    exp_req("s5top", 1'b1, 32'hFFFF_FFFC);
    next_cycle();
    drive(1'b1, mem_word(32'hFFFF_FFFC), 1'b0, 1'b0, '0);
    exp_req("s5wrap", 1'b1, 32'h0);
    next_cycle();
    exp_ifid("s5got", 1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    drive(1'b0, '0, 1'b0, 1'b0, '0);

    // Asynchronous reset while a request is outstanding
    do_reset();
    next_cycle();
    drive(1'b1, mem_word(32'h0), 1'b0, 1'b0, '0);
    next_cycle();
    exp_ifid("s6pre", 1'b1, 32'h0, 32'h0050_0093);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    #1;
    rst_ni = 1'b0;
    #1;
    exp_ifid("s6async", 1'b0, 32'h0, NOP);
    exp_req("s6async", 1'b0, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0);
    exp_req("s6first", 1'b1, 32'h0);
    next_cycle();
    exp_ifid("s6late", 1'b0, 32'h0, NOP);
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    exp_req("s6wait", 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
